serial_add_arbiter: RTL

//  Shares one bit-serial full-add slice (two XOR/AND half-add stages) between NREQ requesters.

---
 rtl/serial_add_pkg.sv | 26 ++
 rtl/fa_bit_slice.sv | 19 +
 rtl/serial_add_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial add arbiter: FSM state encoding,
// id width derivation and extraction of one requester's operand from a packed bus.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SLICE_BUS_MAX = 1024;
  localparam int SLICE_W_MAX   = 64;

  function automatic int idw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Returns bits [k*w +: w] of bus, zero-extended; the caller narrows to its own width.
  function automatic logic [SLICE_W_MAX-1:0] op_slice(input logic [SLICE_BUS_MAX-1:0] bus,
                                                      input int w, input int k);
    logic [SLICE_W_MAX-1:0] mask;
    mask = (SLICE_W_MAX'(1) << w) - SLICE_W_MAX'(1);
    return SLICE_W_MAX'(bus >> (k * w)) & mask;
  endfunction

endpackage

// File: rtl/fa_bit_slice.sv
// Combinational full-add bit slice: two XOR/AND half-add stages joined by an OR
// on the carry path.
module fa_bit_slice (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic h1_s;
  logic h1_c;
  logic h2_c;

  assign h1_s = a ^ b;
  assign h1_c = a & b;
  assign s    = h1_s ^ cin;
  assign h2_c = h1_s & cin;
  assign cout = h1_c | h2_c;
endmodule

// File: rtl/serial_add_arbiter.sv
// Round-robin shares one bit-serial full-add slice among NREQ requesters; each
// operation runs LSB-first over WIDTH cycles and reports with a tagged valid pulse.
module serial_add_arbiter
  import serial_add_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NREQ  = 2,
  localparam int IDW   = idw_of(NREQ)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NREQ-1:0]       i_req,
  input  logic [NREQ*WIDTH-1:0] i_a,
  input  logic [NREQ*WIDTH-1:0] i_b,
  output logic [NREQ-1:0]       o_gnt,
  output logic                  o_busy,
  output logic                  o_valid,
  output logic [WIDTH-1:0]      o_sum,
  output logic                  o_carry,
  output logic [IDW-1:0]        o_id
);
  localparam int CNTW = $clog2(WIDTH);

  state_t            state_q, state_d;
  logic [IDW-1:0]    rr_q, rr_d;
  logic [IDW-1:0]    owner_q, owner_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              c_q, c_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              valid_q, valid_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              carry_q, carry_d;
  logic [IDW-1:0]    id_q, id_d;

  logic              pick_found;
  logic [IDW-1:0]    pick_idx;
  logic              fa_s, fa_co;

  fa_bit_slice u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (c_q),
    .s    (fa_s),
    .cout (fa_co)
  );

  // Scan offsets from the top down so the smallest offset from rr_q wins.
  always_comb begin
    int idx;
    idx        = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = int'(rr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (i_req[IDW'(idx)]) begin
        pick_found = 1'b1;
        pick_idx   = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    gnt_d   = gnt_q;
    valid_d = 1'b0;
    sum_d   = sum_q;
    carry_d = carry_q;
    id_d    = id_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = RUN;
          owner_d = pick_idx;
          gnt_d   = NREQ'(1) << pick_idx;
          a_d     = WIDTH'(op_slice(SLICE_BUS_MAX'(i_a), WIDTH, int'(pick_idx)));
          b_d     = WIDTH'(op_slice(SLICE_BUS_MAX'(i_b), WIDTH, int'(pick_idx)));
          c_d     = 1'b0;
          cnt_d   = '0;
          rr_d    = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + IDW'(1);
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = {fa_s, res_q[WIDTH-1:1]};
        c_d   = fa_co;
        cnt_d = cnt_q + CNTW'(1);
        // The last sum bit is folded straight into the result so it is ready in DONE.
        if (cnt_q == CNTW'(WIDTH - 1)) begin
          state_d = DONE;
          valid_d = 1'b1;
          sum_d   = {fa_s, res_q[WIDTH-1:1]};
          carry_d = fa_co;
          id_d    = owner_q;
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      id_q    <= id_d;
    end
  end

  assign o_gnt   = gnt_q;
  assign o_busy  = (state_q != IDLE);
  assign o_valid = valid_q;
  assign o_sum   = sum_q;
  assign o_carry = carry_q;
  assign o_id    = id_q;

endmodule
